// File: rtl/char_stream_tx.sv
// char_stream_tx: buffered word streamer with strobe for the header link.
// Loads up to DEPTH words, then sends them one per 2*D-cycle slot.
//
// Ports:
//   iCLK, iRST_n                     clock, sync active-low reset
//   iWR_EN, iWR_ADDR, iWR_DATA       buffer write (accepted in IDLE only)
//   iLEN, iDIV                       message length / half-slot divisor
//   iSTART, iREPEAT, iABORT          control
//   oDATA, oSTROBE                   word and latch trigger
//   oBUSY, oDONE, oIDX               status

module char_stream_tx #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int DIV_W  = 24,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic              iWR_EN,
  input  logic [AW-1:0]     iWR_ADDR,
  input  logic [DATA_W-1:0] iWR_DATA,
  input  logic [AW:0]       iLEN,
  input  logic [DIV_W-1:0]  iDIV,
  input  logic              iSTART,
  input  logic              iREPEAT,
  input  logic              iABORT,
  output logic [DATA_W-1:0] oDATA,
  output logic              oSTROBE,
  output logic              oBUSY,
  output logic              oDONE,
  output logic [AW:0]       oIDX
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;

  localparam logic [AW:0]      LEN_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0]      IDX_ONE = (AW+1)'(1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]       state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;
  logic [AW:0]      len_q;

  logic [DIV_W-1:0] div_eff;
  logic [AW:0]      len_eff;
  logic [AW:0]      idx_inc;
  logic             start_ok;
  logic             half_end;
  logic             last_word;
  logic             wr_ok;

  // D=0 would never end a half-slot; treat it as 1
  assign div_eff = (iDIV == '0) ? DIV_ONE : iDIV;
  assign len_eff = (iLEN > LEN_MAX) ? LEN_MAX : iLEN;

  assign start_ok = (state == S_IDLE) && iSTART
                 && !iABORT && (len_eff != '0);

  assign half_end  = (cnt == div_q - DIV_ONE);
  assign last_word = (oIDX == len_q - IDX_ONE);
  assign idx_inc   = oIDX + IDX_ONE;

  // an accepted start takes priority over a same-cycle write
  assign wr_ok = iRST_n && (state == S_IDLE)
              && iWR_EN && !start_ok;

  assign oBUSY = (state != S_IDLE);

  always_ff @(posedge iCLK) begin
    if (wr_ok) begin
      mem[iWR_ADDR] <= iWR_DATA;
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      div_q   <= DIV_ONE;
      len_q   <= '0;
      oDATA   <= '0;
      oSTROBE <= 1'b0;
      oDONE   <= 1'b0;
      oIDX    <= '0;
    end else begin
      oDONE <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_ok) begin
            state <= S_SETUP;
            cnt   <= '0;
            div_q <= div_eff;
            len_q <= len_eff;
            oIDX  <= '0;
            oDATA <= mem[{AW{1'b0}}];
          end
        end
        S_SETUP: begin
          if (iABORT) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (half_end) begin
            state   <= S_STROBE;
            cnt     <= '0;
            oSTROBE <= 1'b1;
          end else begin
            cnt <= cnt + DIV_ONE;
          end
        end
        S_STROBE: begin
          if (iABORT) begin
            state   <= S_IDLE;
            cnt     <= '0;
            oSTROBE <= 1'b0;
          end else if (half_end) begin
            cnt     <= '0;
            oSTROBE <= 1'b0;
            if (!last_word) begin
              state <= S_SETUP;
              oIDX  <= idx_inc;
              oDATA <= mem[idx_inc[AW-1:0]];
            end else begin
              oDONE <= 1'b1;
              if (iREPEAT) begin
                state <= S_SETUP;
                oIDX  <= '0;
                oDATA <= mem[{AW{1'b0}}];
              end else begin
                state <= S_IDLE;
              end
            end
          end else begin
            cnt <= cnt + DIV_ONE;
          end
        end
        default: begin
          state   <= S_IDLE;
          cnt     <= '0;
          oSTROBE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_char_stream_tx.sv
// tb_char_stream_tx: scoreboard bench for char_stream_tx.
// Expected strobes/done pulses are queued at start; a monitor pops them.

module tb_char_stream_tx;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int DIV_W  = 24;
  localparam int AW     = 3;
  localparam int BIG    = 32'h7fff_ffff;

  logic              clk = 1'b0;
  logic              iRST_n;
  logic              iWR_EN;
  logic [AW-1:0]     iWR_ADDR;
  logic [DATA_W-1:0] iWR_DATA;
  logic [AW:0]       iLEN;
  logic [DIV_W-1:0]  iDIV;
  logic              iSTART;
  logic              iREPEAT;
  logic              iABORT;
  logic [DATA_W-1:0] oDATA;
  logic              oSTROBE;
  logic              oBUSY;
  logic              oDONE;
  logic [AW:0]       oIDX;

  char_stream_tx #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .DIV_W (DIV_W)
  ) dut (
    .iCLK    (clk),
    .iRST_n  (iRST_n),
    .iWR_EN  (iWR_EN),
    .iWR_ADDR(iWR_ADDR),
    .iWR_DATA(iWR_DATA),
    .iLEN    (iLEN),
    .iDIV    (iDIV),
    .iSTART  (iSTART),
    .iREPEAT (iREPEAT),
    .iABORT  (iABORT),
    .oDATA   (oDATA),
    .oSTROBE (oSTROBE),
    .oBUSY   (oBUSY),
    .oDONE   (oDONE),
    .oIDX    (oIDX)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         rise;
    int         fall;
    logic [7:0] data;
    int         idx;
  } stb_t;

  typedef struct {
    int   e;
    logic busy;
  } done_t;

  stb_t       sq [$];
  done_t      dq [$];
  logic [7:0] mem_m [DEPTH];

  int    cyc = 0;
  int    n_cmp = 0;
  int    n_err = 0;
  int    done_seen = 0;
  logic  prev_stb = 1'b0;
  logic  have_cur = 1'b0;
  stb_t  cur;
  done_t mon_d;

  // cyc read at a negedge = index of the last rising edge + 1
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @cyc %0d",
               nm, act, exp, cyc);
    end
  endfunction

  function automatic void fail(string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got event, expected none @cyc %0d", nm, cyc);
  endfunction

  always @(negedge clk) begin
    if (oSTROBE === 1'b1 && !prev_stb) begin
      if (sq.size() == 0) begin
        fail("unexpected_strobe");
      end else begin
        cur = sq.pop_front();
        have_cur = 1'b1;
        chk("strobe_rise_edge", cyc - 1, cur.rise);
        chk("strobe_data", 32'(oDATA), 32'(cur.data));
        chk("strobe_idx", 32'(oIDX), cur.idx);
      end
    end else if (oSTROBE === 1'b1 && have_cur) begin
      chk("data_hold", 32'(oDATA), 32'(cur.data));
    end
    if (oSTROBE !== 1'b1 && prev_stb && have_cur) begin
      chk("strobe_fall_edge", cyc - 1, cur.fall);
      have_cur = 1'b0;
    end
    if (oDONE === 1'b1) begin
      done_seen++;
      if (dq.size() == 0) begin
        fail("unexpected_done");
      end else begin
        mon_d = dq.pop_front();
        chk("done_edge", cyc - 1, mon_d.e);
        chk("done_busy", 32'(oBUSY), 32'(mon_d.busy));
      end
    end
    prev_stb = (oSTROBE === 1'b1);
  end

  // reference: word n of pass p strobes over [t+(2n+1)D, t+(2n+2)D),
  // t = k + p*2LD; done at the end of each pass. stop = abort/reset edge.
  task automatic expect_tx(int k, int L, int D, int passes, int stop);
    int le;
    int de;
    int per;
    le  = (L > DEPTH) ? DEPTH : L;
    de  = (D < 1) ? 1 : D;
    per = 2 * le * de;
    for (int p = 0; p < passes; p++) begin
      for (int n = 0; n < le; n++) begin
        stb_t s;
        s.rise = k + p * per + (2 * n + 1) * de;
        s.fall = k + p * per + (2 * n + 2) * de;
        if (s.fall > stop) s.fall = stop;
        s.data = mem_m[n];
        s.idx  = n;
        if (s.rise < stop) sq.push_back(s);
      end
      if (k + (p + 1) * per < stop) begin
        done_t d;
        d.e    = k + (p + 1) * per;
        d.busy = (p < passes - 1);
        dq.push_back(d);
      end
    end
  endtask

  task automatic wr(int a, logic [7:0] d);
    iWR_EN   = 1'b1;
    iWR_ADDR = 3'(a);
    iWR_DATA = d;
    @(negedge clk);
    iWR_EN = 1'b0;
    mem_m[a] = d;
  endtask

  task automatic start(int L, int D, logic rep, output int k);
    iLEN    = 4'(L);
    iDIV    = 24'(D);
    iREPEAT = rep;
    iSTART  = 1'b1;
    @(posedge clk);
    k = cyc;
    @(negedge clk);
    iSTART = 1'b0;
  endtask

  task automatic wait_cyc(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_drain(int budget);
    int n;
    n = 0;
    while ((sq.size() != 0 || dq.size() != 0 || have_cur
            || oBUSY === 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got busy/pending, expected idle");
    end
  endtask

  initial begin
    int k;
    int base;
    int n;
    logic [7:0] msg [6];
    msg = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h0A};

    iRST_n = 1'b0;
    iWR_EN = 1'b0;
    iWR_ADDR = '0;
    iWR_DATA = '0;
    iLEN = '0;
    iDIV = '0;
    iSTART = 1'b0;
    iREPEAT = 1'b0;
    iABORT = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(oDATA), 0);
    chk("rst_strobe", 32'(oSTROBE), 0);
    chk("rst_busy", 32'(oBUSY), 0);
    chk("rst_done", 32'(oDONE), 0);
    chk("rst_idx", 32'(oIDX), 0);
    iRST_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) wr(i, msg[i]);
    wr(6, 8'($urandom));
    wr(7, 8'($urandom));

    // single pass, D=4
    start(6, 4, 1'b0, k);
    chk("busy_after_start", 32'(oBUSY), 1);
    chk("data_at_start", 32'(oDATA), 32'(mem_m[0]));
    chk("idx_at_start", 32'(oIDX), 0);
    expect_tx(k, 6, 4, 1, BIG);
    wait_drain(100);
    chk("idx_hold_end", 32'(oIDX), 5);
    chk("data_hold_end", 32'(oDATA), 32'h0A);

    // repeat: drop iREPEAT after the 2nd done -> 3 passes
    start(6, 4, 1'b1, k);
    expect_tx(k, 6, 4, 3, BIG);
    base = done_seen;
    n = 0;
    while (done_seen < base + 2 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      n_cmp++;
      n_err++;
      $display("FAIL repeat_wait: got %0d dones, expected 2",
               done_seen - base);
    end
    iREPEAT = 1'b0;
    wait_drain(200);

    // abort during word 2 strobe (high over k+20..k+24)
    start(6, 4, 1'b0, k);
    expect_tx(k, 6, 4, 1, k + 22);
    wait_cyc(k + 22);
    iABORT = 1'b1;
    iSTART = 1'b1;
    @(negedge clk);
    iABORT = 1'b0;
    iSTART = 1'b0;
    chk("abort_busy", 32'(oBUSY), 0);
    chk("abort_strobe", 32'(oSTROBE), 0);
    chk("abort_idx", 32'(oIDX), 2);
    chk("abort_data", 32'(oDATA), 32'(mem_m[2]));
    repeat (10) @(negedge clk);
    chk("abort_stays_idle", 32'(oBUSY), 0);
    start(6, 4, 1'b0, k);
    chk("restart_idx", 32'(oIDX), 0);
    expect_tx(k, 6, 4, 1, BIG);
    wait_drain(100);

    // D=0 behaves as D=1; L=0 is ignored
    start(1, 0, 1'b0, k);
    expect_tx(k, 1, 0, 1, BIG);
    wait_drain(20);
    iLEN = '0;
    iDIV = 24'd2;
    iSTART = 1'b1;
    @(negedge clk);
    chk("len0_busy", 32'(oBUSY), 0);
    iSTART = 1'b0;
    repeat (6) @(negedge clk);
    chk("len0_busy_later", 32'(oBUSY), 0);

    // write and start while busy are dropped
    start(6, 2, 1'b0, k);
    expect_tx(k, 6, 2, 1, BIG);
    wait_cyc(k + 2);
    iWR_EN = 1'b1;
    iWR_ADDR = 3'd1;
    iWR_DATA = ~mem_m[1];
    iSTART = 1'b1;
    iLEN = 4'd2;
    iDIV = 24'd7;
    @(negedge clk);
    iWR_EN = 1'b0;
    iSTART = 1'b0;
    wait_drain(100);

    // write + start together in IDLE: start wins, write dropped
    iWR_EN = 1'b1;
    iWR_ADDR = 3'd1;
    iWR_DATA = ~mem_m[1];
    start(3, 1, 1'b0, k);
    iWR_EN = 1'b0;
    expect_tx(k, 3, 1, 1, BIG);
    wait_drain(40);

    // one-cycle reset mid-message (word 1 high over k+9..k+12)
    start(6, 3, 1'b0, k);
    expect_tx(k, 6, 3, 1, k + 10);
    wait_cyc(k + 10);
    iRST_n = 1'b0;
    @(negedge clk);
    iRST_n = 1'b1;
    chk("mrst_data", 32'(oDATA), 0);
    chk("mrst_strobe", 32'(oSTROBE), 0);
    chk("mrst_busy", 32'(oBUSY), 0);
    chk("mrst_idx", 32'(oIDX), 0);
    repeat (20) @(negedge clk);
    chk("mrst_stays_idle", 32'(oBUSY), 0);

    // randomized messages, lengths beyond DEPTH clip
    for (int t = 0; t < 8; t++) begin
      int L;
      int D;
      for (int w = 0; w < 3; w++)
        wr($urandom_range(0, DEPTH - 1), 8'($urandom));
      L = $urandom_range(1, 15);
      D = $urandom_range(0, 4);
      start(L, D, 1'b0, k);
      expect_tx(k, L, D, 1, BIG);
      wait_drain(2 * DEPTH * 4 + 20);
    end

    chk("strobe_queue_left", sq.size(), 0);
    chk("done_queue_left", dq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/char_stream_tx.md
# char_stream_tx

Parametrised character streamer that holds a loadable buffer of up to DEPTH words and transmits them one per slot over a parallel data bus with a strobe, for the external microcontroller link on the Arduino header. It supersedes the fixed six-character, fixed-rate sender used for keyboard-emulation bring-up. New capabilities: runtime-programmable slot rate, variable message length, start/busy/done handshake, abort, and continuous repeat mode. It sits between the board top level (buffer loader / control) and the header pins (data byte + trigger).

## Interface
Parameters:
- DATA_W, 8, width of each transmitted word
- DEPTH, 16, buffer entries (power of two, ≥2); AW = log2(DEPTH)
- DIV_W, 24, width of the half-slot divisor

Ports:
- iCLK  in  1  system clock; all logic on rising edge
- iRST_n  in  1  reset; synchronous, active-low
- iWR_EN  in  1  buffer write enable
- iWR_ADDR  in  AW  buffer write address
- iWR_DATA  in  DATA_W  buffer write data
- iLEN  in  AW+1  words per message, valid 1..DEPTH
- iDIV  in  DIV_W  half-slot length in iCLK cycles (D)
- iSTART  in  1  start request, sampled every cycle
- iREPEAT  in  1  level; 1 = loop message continuously
- iABORT  in  1  stop transmission immediately
- oDATA  out  DATA_W  word currently presented
- oSTROBE  out  1  trigger; receiver latches oDATA on its rising edge
- oBUSY  out  1  transmission in progress
- oDONE  out  1  one-cycle pulse at end of each message pass
- oIDX  out  AW+1  index of word on oDATA

## Operation
- States: IDLE, SETUP (strobe low), STROBE (strobe high). Half-slot counter counts D cycles per state.
- Effective D = max(iDIV, 1); effective L = min(iLEN, DEPTH). iLEN = 0: iSTART ignored.
- iLEN, iDIV latched on accepted start; changes during busy ignored.
- IDLE: iWR_EN writes buf[iWR_ADDR]. Writes while oBUSY=1 dropped. iSTART and iWR_EN same cycle: start accepted, write dropped.
- Start accepted (IDLE, iSTART=1, L≥1, iABORT=0): → SETUP, oIDX=0, oDATA=buf[0], oBUSY=1.
- SETUP after D cycles → STROBE (oSTROBE=1). STROBE after D cycles: if oIDX<L-1 → SETUP with oIDX+1, oDATA=buf[oIDX+1], oSTROBE=0.
- Last word (oIDX=L-1) end of STROBE: oDONE=1 one cycle; if iREPEAT=1 at that edge → SETUP, oIDX=0, oDATA=buf[0], oBUSY stays 1; else → IDLE, oBUSY=0, oSTROBE=0, oDATA/oIDX hold last values.
- iABORT=1 in SETUP/STROBE: next edge → IDLE, oSTROBE=0, oBUSY=0, no oDONE; oDATA/oIDX hold. iABORT beats iSTART. In IDLE: no effect.
- iSTART while busy ignored. Buffer contents undefined after configuration, not cleared by reset.
- Reset (any state, mid-message included): oDATA=0, oSTROBE=0, oBUSY=0, oDONE=0, oIDX=0, state IDLE, counter 0; no oDONE issued.

## Timing
- Start sampled at edge k: oBUSY, oDATA=buf[0] visible after edge k.
- Word n: oDATA valid from edge k+2nD; oSTROBE high from k+(2n+1)D to k+(2n+2)D. Setup and hold of oDATA around strobe rise = D cycles each.
- oDATA changes only on the falling edge of oSTROBE or at start; never while oSTROBE=1.
- Non-repeat end: at edge k+2LD, oBUSY=0 and oDONE=1 simultaneously; new start accepted from that cycle's following edge (iSTART sampled while oBUSY=0).
- Repeat: pass period exactly 2LD cycles, no gap; oDONE pulses at each wrap edge.
- Abort latency: 1 cycle.

## Test plan
- DEPTH=8, load "a","b","c","d","e","\n" at 0..5, iLEN=6, iDIV=4, pulse iSTART -> six strobe highs of 4 cycles, period 8; oDATA 0x61,0x62,0x63,0x64,0x65,0x0A; oDONE at start+48 with oBUSY falling same edge.
- Same, iREPEAT=1, deassert after 2nd oDONE -> 3 full passes (144 cycles), oDONE at +48/+96/+144, oBUSY low after third.
- iABORT mid-STROBE of word 2 -> oSTROBE=0, oBUSY=0 next cycle, no oDONE, oIDX=2; later iSTART restarts from word 0.
- iDIV=0, iLEN=1 -> 1-cycle setup, 1-cycle strobe, oDONE 2 cycles after start; iLEN=0 -> iSTART ignored, oBUSY stays 0.
- iWR_EN to addr 1 during busy and iSTART during busy -> buffer unchanged, transmission unaffected; iWR_EN+iSTART together in IDLE -> start taken, write dropped.
- iRST_n=0 for 1 cycle mid-message -> all outputs 0 next edge; no strobe/oDONE until new start.
